// File: rtl/interval_timer.sv
// interval_timer: memory-mapped down-counting timer with prescaler, reload,
// write-1-to-clear expiry status, level interrupt and a tri-state read port.
module interval_timer #(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned PS_LSB     = 8;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_RELOAD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic                      enable,     enable_n;
  logic                      autoreload, autoreload_n;
  logic                      irq_en,     irq_en_n;
  logic [PRESCALE_WIDTH-1:0] prescale,   prescale_n;
  logic [PRESCALE_WIDTH-1:0] ps_cnt,     ps_cnt_n;
  logic [COUNT_WIDTH-1:0]    count,      count_n;
  logic [COUNT_WIDTH-1:0]    reload,     reload_n;
  logic                      expired,    expired_n;
  logic                      irq_n;
  logic [DATA_WIDTH-1:0]     rd_data,    rd_sel;
  logic                      rd_valid;
  logic                      tick;
  logic                      expire;

  // Next-state: tick effects first, then bus writes override, then expiry set.
  always_comb begin
    enable_n     = enable;
    autoreload_n = autoreload;
    irq_en_n     = irq_en;
    prescale_n   = prescale;
    ps_cnt_n     = ps_cnt;
    count_n      = count;
    reload_n     = reload;
    expired_n    = expired;
    tick         = enable && (ps_cnt == prescale);
    expire       = tick && (count == '0);

    if (!enable || tick) begin
      ps_cnt_n = '0;
    end else begin
      ps_cnt_n = ps_cnt + PRESCALE_WIDTH'(1);
    end

    if (tick) begin
      if (count != '0) begin
        count_n = count - COUNT_WIDTH'(1);
      end else if (autoreload) begin
        count_n = reload;
      end else begin
        enable_n = 1'b0;
      end
    end

    if (we) begin
      case (addr)
        ADDR_CTRL: begin
          enable_n     = wdata[0];
          autoreload_n = wdata[1];
          irq_en_n     = wdata[2];
          prescale_n   = wdata[PS_LSB +: PRESCALE_WIDTH];
          ps_cnt_n     = '0;
        end
        ADDR_COUNT: begin
          count_n  = wdata[COUNT_WIDTH-1:0];
          ps_cnt_n = '0;
        end
        ADDR_RELOAD: reload_n = wdata[COUNT_WIDTH-1:0];
        default: begin
          if (wdata[0]) expired_n = 1'b0;
        end
      endcase
    end

    if (expire) expired_n = 1'b1;

    irq_n = expired_n & irq_en_n;
  end

  // Read mux sees pre-edge register values.
  always_comb begin
    rd_sel = '0;
    case (addr)
      ADDR_CTRL: begin
        rd_sel[0]                        = enable;
        rd_sel[1]                        = autoreload;
        rd_sel[2]                        = irq_en;
        rd_sel[PS_LSB +: PRESCALE_WIDTH] = prescale;
      end
      ADDR_COUNT:  rd_sel = DATA_WIDTH'(count);
      ADDR_RELOAD: rd_sel = DATA_WIDTH'(reload);
      default:     rd_sel[0] = expired;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable     <= 1'b0;
      autoreload <= 1'b0;
      irq_en     <= 1'b0;
      prescale   <= '0;
      ps_cnt     <= '0;
      count      <= '0;
      reload     <= '0;
      expired    <= 1'b0;
      irq        <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      enable     <= enable_n;
      autoreload <= autoreload_n;
      irq_en     <= irq_en_n;
      prescale   <= prescale_n;
      ps_cnt     <= ps_cnt_n;
      count      <= count_n;
      reload     <= reload_n;
      expired    <= expired_n;
      irq        <= irq_n;
      rd_data    <= re ? rd_sel : '0;
      rd_valid   <= re;
    end
  end

  // Release the shared bus whenever no read is being returned.
  assign rdata = rd_valid ? rd_data : 'z;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_interval_timer;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;  // pulled-up bus value when released

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        re    = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] wdata = 32'd0;
  tri1  [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  interval_timer #(.COUNT_WIDTH(32), .PRESCALE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  // Behavioural model: register fields plus cycles elapsed in the current prescale period.
  logic        m_en, m_ar, m_ie, m_exp, m_irq, m_rdv;
  logic [7:0]  m_ps;
  logic [31:0] m_count, m_reload, m_rd;
  int unsigned m_phase;

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_ps, 5'b0, m_ie, m_ar, m_en};
      2'd1:    return m_count;
      2'd2:    return m_reload;
      default: return {31'b0, m_exp};
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_irq = 0; m_rdv = 0;
    m_ps = 0; m_count = 0; m_reload = 0; m_rd = 0; m_phase = 0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic [1:0] a,
                            input logic [31:0] d);
    logic [31:0] rv;
    logic        tk, ex;
    rv = m_reg(a);
    tk = m_en && (m_phase == int'(m_ps));
    ex = tk && (m_count == 0);
    if (!m_en || tk) m_phase = 0;
    else m_phase = m_phase + 1;
    if (tk) begin
      if (m_count != 0) m_count = m_count - 1;
      else if (m_ar) m_count = m_reload;
      else m_en = 0;
    end
    if (w) begin
      case (a)
        2'd0: begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_ps = d[15:8]; m_phase = 0; end
        2'd1: begin m_count = d; m_phase = 0; end
        2'd2: m_reload = d;
        default: if (d[0]) m_exp = 0;
      endcase
    end
    if (ex) m_exp = 1;
    m_irq = m_exp && m_ie;
    m_rdv = r;
    m_rd  = rv;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One bus cycle: drive after an edge, sample 1 time unit after the next edge.
  task automatic step(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    re = r; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    model_step(r, w, a, d);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  function automatic vec_t v(input logic r, input logic w, input logic [1:0] a,
                             input logic [31:0] d, input logic [31:0] er, input logic ei);
    vec_t x;
    x.r = r; x.w = w; x.a = a; x.d = d; x.exp_rd = er; x.exp_irq = ei;
    return x;
  endfunction

  vec_t vt[$];
  int   ar_seq[3] = '{2, 1, 0};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset irq", 32'(irq), 32'd0);
    check("reset rdata idle", rdata, IDLE);
    rst = 1'b1;

    // Reset readback, idle bus, then one-shot countdown from 3.
    vt.push_back(v(1, 0, 2'd0, 0, 32'h0, 0));
    vt.push_back(v(1, 0, 2'd1, 0, 32'h0, 0));
    vt.push_back(v(1, 0, 2'd2, 0, 32'h0, 0));
    vt.push_back(v(1, 0, 2'd3, 0, 32'h0, 0));
    vt.push_back(v(0, 0, 2'd0, 0, IDLE, 0));
    vt.push_back(v(0, 1, 2'd1, 3, IDLE, 0));
    vt.push_back(v(0, 1, 2'd0, 32'h5, IDLE, 0));
    vt.push_back(v(1, 0, 2'd1, 0, 32'd3, 0));
    vt.push_back(v(1, 0, 2'd1, 0, 32'd2, 0));
    vt.push_back(v(1, 0, 2'd1, 0, 32'd1, 0));
    vt.push_back(v(1, 0, 2'd1, 0, 32'd0, 1));
    vt.push_back(v(1, 0, 2'd1, 0, 32'd0, 1));
    vt.push_back(v(1, 0, 2'd0, 0, 32'h4, 1));
    vt.push_back(v(1, 0, 2'd3, 0, 32'h1, 1));
    vt.push_back(v(0, 1, 2'd3, 32'h1, IDLE, 0));
    vt.push_back(v(1, 0, 2'd3, 0, 32'h0, 0));
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].w, vt[i].a, vt[i].d);
      check($sformatf("vec%0d rdata", i), rdata, vt[i].exp_rd);
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vt[i].exp_irq));
    end

    // Autoreload with prescale 3: a tick every 4 clocks, count 2,1,0,2,1,0.
    step(0, 1, 2'd2, 32'd2);
    step(0, 1, 2'd1, 32'd2);
    step(0, 1, 2'd0, 32'h303);
    for (int k = 1; k <= 24; k++) begin
      step(1, 0, 2'd1, 0);
      check($sformatf("autoreload count k=%0d", k), rdata, 32'(ar_seq[((k - 1) / 4) % 3]));
    end
    step(1, 0, 2'd0, 0);
    check("autoreload ctrl", rdata, 32'h303);
    step(1, 0, 2'd3, 0);
    check("autoreload expired", rdata, 32'h1);
    check("autoreload irq off", 32'(irq), 32'd0);

    // Status clear in the exact expiry cycle: set wins; a later clear drops irq.
    step(0, 1, 2'd0, 0);
    step(0, 1, 2'd3, 32'h1);
    step(0, 1, 2'd1, 0);
    step(0, 1, 2'd0, 32'h5);
    step(0, 1, 2'd3, 32'h1);
    check("w1c collision irq", 32'(irq), 32'd1);
    step(1, 0, 2'd3, 0);
    check("w1c collision expired", rdata, 32'h1);
    step(0, 1, 2'd3, 32'h1);
    check("w1c irq drop", 32'(irq), 32'd0);
    step(1, 0, 2'd3, 0);
    check("w1c expired cleared", rdata, 32'h0);

    // COUNT write in a tick cycle wins over the decrement.
    step(0, 1, 2'd0, 0);
    step(0, 1, 2'd1, 32'd10);
    step(0, 1, 2'd0, 32'h1);
    step(0, 1, 2'd1, 32'd100);
    step(1, 0, 2'd1, 0);
    check("write/tick first", rdata, 32'd100);
    step(1, 0, 2'd1, 0);
    check("write/tick second", rdata, 32'd99);

    // Async reset between edges while count=5 and irq=1.
    step(0, 1, 2'd0, 0);
    step(0, 1, 2'd2, 32'd5);
    step(0, 1, 2'd1, 0);
    step(0, 1, 2'd0, 32'h7);
    step(0, 1, 2'd0, 32'h4);
    check("pre-reset irq", 32'(irq), 32'd1);
    step(1, 0, 2'd1, 0);
    check("pre-reset count", rdata, 32'd5);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("async reset irq", 32'(irq), 32'd0);
    check("async reset rdata idle", rdata, IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      step(1, 0, 2'(a), 0);
      check($sformatf("post-reset reg%0d", a), rdata, 32'h0);
      check($sformatf("post-reset irq%0d", a), 32'(irq), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        r, w;
      logic [1:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd0) d[15:8] = 8'($urandom_range(0, 3));
      if (a == 2'd1) d = 32'($urandom_range(0, 6));
      if (a == 2'd2) d = 32'($urandom_range(0, 5));
      step(r, w, a, d);
      check($sformatf("rand%0d rdata", i), rdata, m_rdv ? m_rd : IDLE);
      check($sformatf("rand%0d irq", i), 32'(irq), 32'(m_irq));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
